// File: rtl/img_pkg.sv
// Shared image-stream defaults and window tap helpers.
// No logic and no latency: constants and a pure function only.
// No backpressure: nothing in here carries flow control.
package img_pkg;

  localparam int DATA_W_DEF       = 11;
  localparam int IMAGE_WIDTH_DEF  = 506;
  localparam int IMAGE_HEIGHT_DEF = 506;

  // Flat tap number of window element (row r, column c) for a window of side k.
  // Row 0 is the oldest (top) line and column 0 the oldest (left) pixel.
  // Downstream blocks unpack win_out with win_out[tap_index(r,c,k)*DATA_W +: DATA_W].
  function automatic int tap_index(input int r, input int c, input int k);
    return r * k + c;
  endfunction

endpackage

// File: rtl/line_ram.sv
// One image line of storage: single-port RAM, read-before-write.
// Latency: combinational read at addr; a write takes effect at the next edge.
// No backpressure: a write happens on every cycle that we is high.
//
// Ports:
//   clk     rising-edge clock
//   we      write enable
//   addr    shared read/write address
//   wr_data value written at addr
//   rd_data old contents at addr, i.e. the value before this cycle's write
module line_ram #(
  parameter int DEPTH  = 506,
  parameter int DATA_W = 11,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // The asynchronous read gives the old word in the same cycle as the write.
  // That keeps the cascade to the next line and the window load at one cycle.
  assign rd_data = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/window_line_buffer.sv
// (2R+1)x(2R+1) sliding window over a raster pixel stream, with the window centre coordinates.
// Latency: the window for accepted pixel (col,row) appears registered one cycle after the accept.
// Backpressure: none, the input is accepted whenever in_valid is high. Idle cycles freeze all state.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   in_valid   accept in_data this cycle
//   in_sof     with in_valid: the pixel is (0,0) of a new frame
//   in_data    pixel value
//   win_out    K*K taps; tap r*K+c is at [tap*DATA_W +: DATA_W], r=0 top row, c=0 left column
//   out_valid  one-cycle pulse; the window lies fully inside the image
//   out_x/y    centre column and centre row of the presented window
module window_line_buffer
  import img_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int IMAGE_WIDTH  = IMAGE_WIDTH_DEF,
  parameter int IMAGE_HEIGHT = IMAGE_HEIGHT_DEF,
  parameter int R            = 1,
  localparam int K    = 2 * R + 1,
  localparam int TAPS = K * K,
  localparam int XW   = $clog2(IMAGE_WIDTH),
  localparam int YW   = $clog2(IMAGE_HEIGHT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_sof,
  input  logic [DATA_W-1:0]      in_data,
  output logic [TAPS*DATA_W-1:0] win_out,
  output logic                   out_valid,
  output logic [XW-1:0]          out_x,
  output logic [YW-1:0]          out_y
);

  localparam int NRAM = 2 * R;

  localparam logic [XW-1:0] COL_LAST = XW'(IMAGE_WIDTH - 1);
  localparam logic [YW-1:0] ROW_LAST = YW'(IMAGE_HEIGHT - 1);
  localparam logic [XW-1:0] COL_MIN  = XW'(2 * R);
  localparam logic [YW-1:0] ROW_MIN  = YW'(2 * R);
  localparam logic [XW-1:0] COL_OFS  = XW'(R);
  localparam logic [YW-1:0] ROW_OFS  = YW'(R);

  logic [XW-1:0] col, col_cur, col_nxt;
  logic [YW-1:0] row, row_cur, row_nxt;
  logic          accept;

  logic [DATA_W-1:0] ram_rd  [NRAM];
  logic [DATA_W-1:0] ram_wr  [NRAM];
  logic [DATA_W-1:0] new_col [K];
  logic [DATA_W-1:0] win     [K][K];

  assign accept = in_valid && !rst;

  // An accepted start-of-frame is handled as position (0,0), whatever the counters hold.
  // The RAM address and the validity test use this position too, so a resync
  // writes the new frame's first line at the correct columns.
  always_comb begin
    col_cur = in_sof ? '0 : col;
    row_cur = in_sof ? '0 : row;
    col_nxt = col_cur + 1'b1;
    row_nxt = row_cur;
    if (col_cur == COL_LAST) begin
      col_nxt = '0;
      row_nxt = (row_cur == ROW_LAST) ? '0 : row_cur + 1'b1;
    end
  end

  // Line cascade. RAM 0 holds the previous line and RAM 2R-1 the oldest line.
  // Each RAM passes its old word at col on to the next RAM.
  for (genvar j = 0; j < NRAM; j++) begin : g_line
    if (j == 0) begin : g_first
      assign ram_wr[j] = in_data;
    end else begin : g_next
      assign ram_wr[j] = ram_rd[j-1];
    end

    line_ram #(
      .DEPTH  (IMAGE_WIDTH),
      .DATA_W (DATA_W),
      .AW     (XW)
    ) u_line_ram (
      .clk     (clk),
      .we      (accept),
      .addr    (col_cur),
      .wr_data (ram_wr[j]),
      .rd_data (ram_rd[j])
    );
  end

  // New right-hand column. The top row takes the oldest line and the bottom row the live pixel.
  always_comb begin
    for (int r = 0; r < K; r++) begin
      new_col[r] = in_data;
    end
    for (int r = 0; r < NRAM; r++) begin
      new_col[r] = ram_rd[NRAM-1-r];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win[r][c] <= '0;
        end
      end
    end else if (in_valid) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          win[r][c] <= win[r][c+1];
        end
        win[r][K-1] <= new_col[r];
      end
      col <= col_nxt;
      row <= row_nxt;
      // The window is fully inside the image only after 2R columns of this line
      // and 2R full lines of this frame. So no valid window spans a line wrap
      // or uses stale RAM contents.
      out_valid <= (col_cur >= COL_MIN) && (row_cur >= ROW_MIN);
      out_x     <= col_cur - COL_OFS;
      out_y     <= row_cur - ROW_OFS;
    end else begin
      out_valid <= 1'b0;
    end
  end

  always_comb begin
    win_out = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        win_out[tap_index(r, c, K)*DATA_W +: DATA_W] = win[r][c];
      end
    end
  end

endmodule

// File: tb/tb_window_line_buffer.sv
module tb_window_line_buffer;

  localparam int DW = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  // Instance A: R=1 on an 8x6 image
  logic          va = 1'b0, sa = 1'b0;
  logic [DW-1:0] da = '0;
  logic [9*DW-1:0] wa;
  logic          ova;
  logic [2:0]    xa;
  logic [2:0]    ya;

  // Instance B: R=2 on a 10x7 image
  logic          vb = 1'b0, sb = 1'b0;
  logic [DW-1:0] db = '0;
  logic [25*DW-1:0] wb;
  logic          ovb;
  logic [3:0]    xb;
  logic [2:0]    yb;

  int vec = 0;
  int mis = 0;

  window_line_buffer #(.DATA_W(DW), .IMAGE_WIDTH(8), .IMAGE_HEIGHT(6), .R(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(va), .in_sof(sa), .in_data(da),
    .win_out(wa), .out_valid(ova), .out_x(xa), .out_y(ya)
  );

  window_line_buffer #(.DATA_W(DW), .IMAGE_WIDTH(10), .IMAGE_HEIGHT(7), .R(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(vb), .in_sof(sb), .in_data(db),
    .win_out(wb), .out_valid(ovb), .out_x(xb), .out_y(yb)
  );

  // Drive one cycle on instance A and sample its outputs 1 time unit after the edge.
  task automatic step_a(input logic v, input logic s, input logic [DW-1:0] d);
    @(negedge clk);
    va = v; sa = s; da = d;
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input logic v, input logic s, input logic [DW-1:0] d);
    @(negedge clk);
    vb = v; sb = s; db = d;
    @(posedge clk);
    #1;
  endtask

  // One full 8x6 frame on A, pixel = off + 16*y + x, with in_sof on the first pixel.
  // Every output cycle is checked against the expected window. The expected
  // window is centred at (x-1,y-1), with tap (r,c) = off + 16*(y-2+r) + (x-2+c).
  task automatic run_frame_a(input int off, input int idle_pct,
                             output int pulses, output int first_acc,
                             output int first_y, output int first_tap0,
                             output int last_x, output int last_y, output int last_tap8);
    int acc;
    int n_idle;
    logic exp_v;
    logic [DW-1:0] got;
    int want;
    acc = 0; pulses = 0; first_acc = -1; first_y = -1; first_tap0 = -1;
    last_x = -1; last_y = -1; last_tap8 = -1;
    for (int y = 0; y < 6; y++) begin
      for (int x = 0; x < 8; x++) begin
        n_idle = 0;
        while (idle_pct > 0 && n_idle < 4 && $urandom_range(99) < idle_pct) begin
          // Idle cycles carry a stray in_sof and junk data, which must be ignored.
          step_a(1'b0, 1'($urandom_range(1)), 11'($urandom_range(2047)));
          n_idle++;
          vec++;
          if (ova !== 1'b0) begin
            mis++;
            $display("FAIL idle_valid_a at (%0d,%0d): got %0b want 0", x, y, ova);
          end
        end
        step_a(1'b1, (x == 0 && y == 0), 11'(off + 16*y + x));
        acc++;
        exp_v = (x >= 2 && y >= 2);
        vec++;
        if (ova !== exp_v) begin
          mis++;
          $display("FAIL valid_a at (%0d,%0d): got %0b want %0b", x, y, ova, exp_v);
        end
        if (ova === 1'b1) begin
          pulses++;
          if (first_acc < 0) begin
            first_acc  = acc;
            first_y    = int'(ya);
            first_tap0 = int'(wa[0 +: DW]);
          end
          last_x    = int'(xa);
          last_y    = int'(ya);
          last_tap8 = int'(wa[8*DW +: DW]);
        end
        if (exp_v) begin
          vec++;
          if (xa !== 3'(x - 1) || ya !== 3'(y - 1)) begin
            mis++;
            $display("FAIL centre_a at (%0d,%0d): got (%0d,%0d) want (%0d,%0d)", x, y, xa, ya, x-1, y-1);
          end
          for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
              got  = wa[(r*3+c)*DW +: DW];
              want = off + 16*(y-2+r) + (x-2+c);
              vec++;
              if (got !== 11'(want)) begin
                mis++;
                $display("FAIL tap_a t%0d at (%0d,%0d): got %0d want %0d", r*3+c, x, y, got, want);
              end
            end
          end
        end
      end
    end
  endtask

  task automatic test_reset;
    // rst must win over an active in_valid/in_sof
    @(negedge clk);
    rst = 1'b1; va = 1'b1; sa = 1'b1; da = 11'd5; vb = 1'b1; sb = 1'b1; db = 11'd7;
    @(posedge clk); @(posedge clk); #1;
    vec++;
    if (ova !== 1'b0 || wa !== '0 || xa !== 3'd0 || ya !== 3'd0) begin
      mis++;
      $display("FAIL reset_a: got valid=%0b win=%0h x=%0d y=%0d want all 0", ova, wa, xa, ya);
    end
    vec++;
    if (ovb !== 1'b0 || wb !== '0 || xb !== 4'd0 || yb !== 3'd0) begin
      mis++;
      $display("FAIL reset_b: got valid=%0b win=%0h x=%0d y=%0d want all 0", ovb, wb, xb, yb);
    end
    @(negedge clk);
    rst = 1'b0; va = 1'b0; sa = 1'b0; vb = 1'b0; sb = 1'b0;
  endtask

  task automatic test_continuous;
    int p, fa, fy, ft0, lx, ly, lt8;
    run_frame_a(0, 0, p, fa, fy, ft0, lx, ly, lt8);
    vec++;
    if (p !== 24) begin mis++; $display("FAIL cont_pulses: got %0d want 24", p); end
    vec++;
    if (fa !== 19) begin mis++; $display("FAIL cont_first_acc: got %0d want 19", fa); end
    vec++;
    if (lx !== 6 || ly !== 4 || lt8 !== 87) begin
      mis++;
      $display("FAIL cont_last: got (%0d,%0d) tap8=%0d want (6,4) tap8=87", lx, ly, lt8);
    end
  endtask

  task automatic test_idle;
    int p, fa, fy, ft0, lx, ly, lt8;
    run_frame_a(0, 40, p, fa, fy, ft0, lx, ly, lt8);
    vec++;
    if (p !== 24) begin mis++; $display("FAIL idle_pulses: got %0d want 24", p); end
    vec++;
    if (lx !== 6 || ly !== 4 || lt8 !== 87) begin
      mis++;
      $display("FAIL idle_last: got (%0d,%0d) tap8=%0d want (6,4) tap8=87", lx, ly, lt8);
    end
  endtask

  task automatic test_mid_reset;
    int p, fa, fy, ft0, lx, ly, lt8;
    for (int i = 0; i < 30; i++) begin
      step_a(1'b1, (i == 0), 11'(16*(i/8) + (i%8)));
    end
    @(negedge clk);
    rst = 1'b1; va = 1'b1; sa = 1'b0; da = 11'd1234;
    @(posedge clk); #1;
    vec++;
    if (ova !== 1'b0 || wa !== '0) begin
      mis++;
      $display("FAIL midrst_clear: got valid=%0b win=%0h want 0", ova, wa);
    end
    @(negedge clk);
    rst = 1'b0; va = 1'b0;
    run_frame_a(0, 0, p, fa, fy, ft0, lx, ly, lt8);
    vec++;
    if (fa !== 19 || p !== 24) begin
      mis++;
      $display("FAIL midrst_restart: got first=%0d pulses=%0d want 19 and 24", fa, p);
    end
  endtask

  task automatic test_back_to_back;
    int p1, p2, fa, fy, ft0, lx, ly, lt8;
    run_frame_a(0, 0, p1, fa, fy, ft0, lx, ly, lt8);
    run_frame_a(100, 0, p2, fa, fy, ft0, lx, ly, lt8);
    vec++;
    if (p1 + p2 !== 48) begin mis++; $display("FAIL b2b_pulses: got %0d want 48", p1 + p2); end
    vec++;
    if (fy !== 1 || ft0 !== 100) begin
      mis++;
      $display("FAIL b2b_first: got y=%0d tap0=%0d want y=1 tap0=100", fy, ft0);
    end
    vec++;
    if (lt8 !== 187) begin mis++; $display("FAIL b2b_last_tap8: got %0d want 187", lt8); end
  endtask

  task automatic test_sof_resync;
    int p, fa, fy, ft0, lx, ly, lt8;
    // A partial stream of junk, then a start-of-frame in the middle of a line
    for (int i = 0; i < 13; i++) begin
      step_a(1'b1, 1'b0, 11'd2000);
      vec++;
      if (ova !== 1'b0) begin mis++; $display("FAIL resync_junk_valid i=%0d: got %0b want 0", i, ova); end
    end
    run_frame_a(0, 0, p, fa, fy, ft0, lx, ly, lt8);
    vec++;
    if (fa !== 19 || p !== 24 || ft0 !== 0) begin
      mis++;
      $display("FAIL resync_frame: got first=%0d pulses=%0d tap0=%0d want 19, 24, 0", fa, p, ft0);
    end
  endtask

  task automatic test_r2;
    int acc, pulses, first_acc, want;
    logic exp_v;
    logic [DW-1:0] got;
    acc = 0; pulses = 0; first_acc = -1;
    for (int y = 0; y < 7; y++) begin
      for (int x = 0; x < 10; x++) begin
        step_b(1'b1, (x == 0 && y == 0), 11'(16*y + x));
        acc++;
        exp_v = (x >= 4 && y >= 4);
        vec++;
        if (ovb !== exp_v) begin
          mis++;
          $display("FAIL valid_b at (%0d,%0d): got %0b want %0b", x, y, ovb, exp_v);
        end
        if (ovb === 1'b1) begin
          pulses++;
          if (first_acc < 0) begin
            first_acc = acc;
            vec++;
            if (xb !== 4'd2 || yb !== 3'd2 || wb[0 +: DW] !== 11'd0 ||
                wb[12*DW +: DW] !== 11'd34 || wb[24*DW +: DW] !== 11'd68) begin
              mis++;
              $display("FAIL r2_first: got (%0d,%0d) t0=%0d t12=%0d t24=%0d want (2,2) 0 34 68",
                       xb, yb, wb[0 +: DW], wb[12*DW +: DW], wb[24*DW +: DW]);
            end
          end
        end
        if (exp_v) begin
          vec++;
          if (xb !== 4'(x - 2) || yb !== 3'(y - 2)) begin
            mis++;
            $display("FAIL centre_b at (%0d,%0d): got (%0d,%0d) want (%0d,%0d)", x, y, xb, yb, x-2, y-2);
          end
          for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
              got  = wb[(r*5+c)*DW +: DW];
              want = 16*(y-4+r) + (x-4+c);
              vec++;
              if (got !== 11'(want)) begin
                mis++;
                $display("FAIL tap_b t%0d at (%0d,%0d): got %0d want %0d", r*5+c, x, y, got, want);
              end
            end
          end
        end
      end
    end
    vec++;
    if (first_acc !== 45) begin mis++; $display("FAIL r2_first_acc: got %0d want 45", first_acc); end
    vec++;
    if (pulses !== 18) begin mis++; $display("FAIL r2_pulses: got %0d want 18", pulses); end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_idle();
    test_mid_reset();
    test_back_to_back();
    test_sof_resync();
    test_r2();
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
